// File: rtl/order_tx_framer_if.sv
// Order-strobe and exchange-link signal bundle for order_tx_framer.
// master: upstream order source plus link sink; slave: the framer itself.
interface order_tx_framer_if;
  logic        order_go;
  logic [4:0]  order_client_id;
  logic [15:0] order_amount;
  logic        order_full;
  logic [7:0]  link_data;
  logic        link_valid;
  logic        link_sof;
  logic        link_ready;

  modport master (
    output order_go, order_client_id, order_amount, link_ready,
    input  order_full, link_data, link_valid, link_sof
  );

  modport slave (
    input  order_go, order_client_id, order_amount, link_ready,
    output order_full, link_data, link_valid, link_sof
  );
endinterface

// File: rtl/order_tx_framer.sv
// Order transmit framer: queues order strobes in a FIFO and serialises them as byte frames.
// Define ORDER_TX_CSUM_EN to append an XOR checksum byte (5-byte frames instead of 4).
module order_tx_framer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  SOF_BYTE   = 8'hA5
) (
  input  logic               clk,
  input  logic               HRESETn,
  order_tx_framer_if.slave   bus,
  output logic [7:0]         drop_count,
  output logic               busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    CLIENT,
    AMT_HI,
    AMT_LO
`ifdef ORDER_TX_CSUM_EN
    , CSUM
`endif
  } state_t;

  state_t      state, state_nxt;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [20:0] mem [FIFO_DEPTH];
  logic [20:0] frame_q;
  logic        fifo_empty;
  logic        push, pop;
  logic [7:0]  byte_client, byte_amt_hi, byte_amt_lo;

  assign fifo_empty    = (wr_ptr == rd_ptr);
  assign bus.order_full = (wr_ptr[AW] != rd_ptr[AW]) &&
                          (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Rejection is decided on the registered full flag; a same-cycle pop does not help.
  assign push = bus.order_go && !bus.order_full;
  assign busy = (state != IDLE) || !fifo_empty;

  assign byte_client = {3'b000, frame_q[20:16]};
  assign byte_amt_hi = frame_q[15:8];
  assign byte_amt_lo = frame_q[7:0];

  always_comb begin
    state_nxt      = state;
    pop            = 1'b0;
    bus.link_valid = 1'b1;
    bus.link_sof   = 1'b0;
    bus.link_data  = '0;
    case (state)
      IDLE: begin
        bus.link_valid = 1'b0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = SOF;
        end
      end
      SOF: begin
        bus.link_sof  = 1'b1;
        bus.link_data = SOF_BYTE;
        if (bus.link_ready) state_nxt = CLIENT;
      end
      CLIENT: begin
        bus.link_data = byte_client;
        if (bus.link_ready) state_nxt = AMT_HI;
      end
      AMT_HI: begin
        bus.link_data = byte_amt_hi;
        if (bus.link_ready) state_nxt = AMT_LO;
      end
      AMT_LO: begin
        bus.link_data = byte_amt_lo;
        if (bus.link_ready) begin
`ifdef ORDER_TX_CSUM_EN
          state_nxt = CSUM;
`else
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = SOF;
          end else begin
            state_nxt = IDLE;
          end
`endif
        end
      end
`ifdef ORDER_TX_CSUM_EN
      CSUM: begin
        bus.link_data = byte_client ^ byte_amt_hi ^ byte_amt_lo;
        if (bus.link_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = SOF;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
`endif
      default: begin
        bus.link_valid = 1'b0;
        state_nxt      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge HRESETn) begin
    if (HRESETn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      frame_q    <= '0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        frame_q <= mem[rd_ptr[AW-1:0]];
      end
      if (bus.order_go && bus.order_full && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {bus.order_client_id, bus.order_amount};
  end

endmodule

// File: tb/tb_order_tx_framer.sv
// Directed bench for order_tx_framer: single frame, backpressure, overflow,
// back-to-back frames and mid-frame reset, for either frame length.
module tb_order_tx_framer;

`ifdef ORDER_TX_CSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] drop_count;
  logic       busy;
  int         n_checks;
  int         n_pass;

  order_tx_framer_if bus();

  order_tx_framer #(.FIFO_DEPTH(4), .SOF_BYTE(8'hA5)) dut (
    .clk        (clk),
    .HRESETn    (rst),
    .bus        (bus),
    .drop_count (drop_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_order(input logic [4:0] cid, input logic [15:0] amt);
    bus.order_go        = 1'b1;
    bus.order_client_id = cid;
    bus.order_amount    = amt;
    tick();
    bus.order_go = 1'b0;
  endtask

  function automatic logic [7:0] frame_byte(input int i, input logic [4:0] cid, input logic [15:0] amt);
    logic [7:0] c;
    c = {3'b000, cid};
    case (i)
      0: return 8'hA5;
      1: return c;
      2: return amt[15:8];
      3: return amt[7:0];
      default: return c ^ amt[15:8] ^ amt[7:0];
    endcase
  endfunction

  // Assumes link_ready=1; checks NB consecutive bytes starting once valid appears.
  task automatic recv_frame(input string tag, input logic [4:0] cid, input logic [15:0] amt);
    int w;
    w = 0;
    while (!bus.link_valid && w < 20) begin
      tick();
      w++;
    end
    if (!bus.link_valid) check({tag, "_timeout"}, 0, 1);
    for (int i = 0; i < NB; i++) begin
      check($sformatf("%s_data%0d", tag, i), bus.link_data, frame_byte(i, cid, amt));
      check($sformatf("%s_sof%0d", tag, i), bus.link_sof, (i == 0));
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst                 = 1'b1;
    bus.order_go        = 1'b0;
    bus.order_client_id = '0;
    bus.order_amount    = '0;
    bus.link_ready      = 1'b1;
    tick();
    tick();
    check("rst_valid", bus.link_valid, 0);
    check("rst_data",  bus.link_data, 8'h00);
    check("rst_sof",   bus.link_sof, 0);
    check("rst_full",  bus.order_full, 0);
    check("rst_busy",  busy, 0);
    check("rst_drop",  drop_count, 0);
    rst = 1'b0;
    tick();

    // Single frame: client 3, amount 1234 -> A5 03 12 34 (25)
    push_order(5'd3, 16'h1234);
    check("t1_busy_n1",  busy, 1);
    check("t1_valid_n1", bus.link_valid, 0);
    tick();
    check("t1_valid_n2", bus.link_valid, 1);
    check("t1_b0", bus.link_data, 8'hA5);
    check("t1_sof0", bus.link_sof, 1);
    tick();
    check("t1_b1", bus.link_data, 8'h03);
    check("t1_sof1", bus.link_sof, 0);
    tick();
    check("t1_b2", bus.link_data, 8'h12);
    tick();
    check("t1_b3", bus.link_data, 8'h34);
    tick();
    if (NB == 5) begin
      check("t1_b4", bus.link_data, 8'h25);
      check("t1_v4", bus.link_valid, 1);
      tick();
    end
    check("t1_end_valid", bus.link_valid, 0);
    check("t1_end_busy", busy, 0);

    // Backpressure on AMT_HI
    push_order(5'd3, 16'h1234);
    tick();
    check("t2_b0", bus.link_data, 8'hA5);
    tick();
    check("t2_b1", bus.link_data, 8'h03);
    tick();
    bus.link_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_hold_data%0d", i), bus.link_data, 8'h12);
      check($sformatf("t2_hold_valid%0d", i), bus.link_valid, 1);
      check($sformatf("t2_hold_sof%0d", i), bus.link_sof, 0);
      tick();
    end
    bus.link_ready = 1'b1;
    check("t2_b2", bus.link_data, 8'h12);
    tick();
    check("t2_b3", bus.link_data, 8'h34);
    tick();
    if (NB == 5) begin
      check("t2_b4", bus.link_data, 8'h25);
      tick();
    end
    check("t2_end_valid", bus.link_valid, 0);

    // Overflow: 6 strobes at depth 4 with the link stalled
    bus.link_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push_order(5'd7, 16'(i));
    check("t3_full", bus.order_full, 1);
    check("t3_drop", drop_count, 1);
    check("t3_sof_held", bus.link_sof, 1);
    bus.link_ready = 1'b1;
    for (int i = 1; i <= 5; i++) recv_frame($sformatf("t3_f%0d", i), 5'd7, 16'(i));
    check("t3_end_valid", bus.link_valid, 0);
    check("t3_end_full", bus.order_full, 0);
    check("t3_drop_keep", drop_count, 1);

    // Back-to-back frames
    bus.link_ready = 1'b0;
    push_order(5'd1, 16'hAAAA);
    push_order(5'd2, 16'h0055);
    bus.link_ready = 1'b1;
    recv_frame("t4_f1", 5'd1, 16'hAAAA);
    check("t4_b2b_sof", bus.link_sof, 1);
    check("t4_b2b_data", bus.link_data, 8'hA5);
    recv_frame("t4_f2", 5'd2, 16'h0055);
    check("t4_end_valid", bus.link_valid, 0);
    check("t4_end_busy", busy, 0);

    // Reset while AMT_LO is presented with two orders queued
    bus.link_ready = 1'b0;
    push_order(5'd4, 16'hBEEF);
    push_order(5'd5, 16'h0001);
    push_order(5'd6, 16'h0002);
    check("t5_sof", bus.link_sof, 1);
    bus.link_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.link_ready = 1'b0;
    check("t5_amt_lo", bus.link_data, 8'hEF);
    #2 rst = 1'b1;
    #1;
    check("t5_async_valid", bus.link_valid, 0);
    check("t5_async_data", bus.link_data, 8'h00);
    check("t5_async_busy", busy, 0);
    tick();
    rst = 1'b0;
    bus.link_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5_idle_valid%0d", i), bus.link_valid, 0);
      tick();
    end
    check("t5_busy", busy, 0);
    check("t5_full", bus.order_full, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/order_tx_framer.md
# order_tx_framer

Transmit end of the order path. Accepts risk-approved orders as single-cycle strobes from the upstream processor, queues them in a small FIFO, and serialises each order into a byte frame on a valid/ready link toward the exchange. It is the counterpart of the exchange-side receive path, which delivers `exchange_go`, client-ID and amount strobes into the downstream cache.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: order queue depth; must be a power of 2, minimum 2.
- `SOF_BYTE`, default 8'hA5: start-of-frame marker byte.

Ports:
- `clk`  in  1  — single clock; all logic on its rising edge.
- `HRESETn`  in  1  — reset, asynchronous, active-high.
- `order_go`  in  1  — one-cycle strobe; capture one order.
- `order_client_id`  in  5  — client index, sampled with `order_go`.
- `order_amount`  in  16  — order quantity, sampled with `order_go`.
- `order_full`  out  1  — FIFO holds `FIFO_DEPTH` entries.
- `link_data`  out  8  — current frame byte.
- `link_valid`  out  1  — `link_data` is valid.
- `link_sof`  out  1  — high with the first byte of each frame only.
- `link_ready`  in  1  — sink accepts the byte when `link_valid` is also high.
- `drop_count`  out  8  — orders rejected because the FIFO was full; saturates at 255.
- `busy`  out  1  — high when the FSM is not in IDLE or the FIFO is not empty.

## Operation

- **Push:** `order_go` with `order_full`=0 writes {client_id, amount} into the FIFO.
- **Full rejection:** `order_go` with `order_full`=1 is dropped and `drop_count` increments.
  - The decision uses the registered `order_full` only; a pop in the same cycle does not rescue the order.
- **Frame format (checksum enabled):** SOF_BYTE, {3'b000, client_id}, amount[15:8], amount[7:0], checksum.
  - checksum = byte1 ^ byte2 ^ byte3. The SOF byte is excluded.
- **FSM states:** IDLE, SOF, CLIENT, AMT_HI, AMT_LO, CSUM.
  - IDLE: if the FIFO is not empty, pop the head into the frame register and go to SOF.
  - SOF→CLIENT→AMT_HI→AMT_LO→CSUM: each step advances only on `link_valid & link_ready`.
  - CSUM accepted: if the FIFO is not empty, pop and go directly to SOF, with no idle cycle between frames. Otherwise go to IDLE.
- **Outputs by state:** `link_valid`=1 in every state except IDLE. `link_sof`=1 only in SOF.
- **Backpressure:** while `link_valid`=1 and `link_ready`=0, `link_data`, `link_sof` and the state hold stable. Valid is never withdrawn before acceptance.
- **Ordering:** frames leave strictly in FIFO order. Pushes during transmission do not disturb the frame register.
- **Simultaneous push and pop:** allowed when the FIFO is not full. Count is unchanged.
- **Pointers:** log2(FIFO_DEPTH)+1 bits, wrapping naturally. Full = pointer MSBs differ and the lower bits are equal.

## Timing

- **Reset values:** all outputs are 0 (`link_data`=8'h00, `link_valid`, `link_sof`, `order_full`, `busy`, `drop_count`). FIFO empty, state IDLE.
- **Reset mid-frame:** asynchronous assertion clears outputs immediately. The partial frame is abandoned and never resumed, and all queued orders are discarded.
- **Latency from idle:**
  - `order_go` in cycle N → FIFO not empty at edge N.
  - Pop at edge N+1 → `link_valid`=1 with SOF_BYTE in cycle N+2.
- **Throughput:** with `link_ready` held at 1, a frame takes 5 cycles (4 without checksum). Consecutive frames are contiguous.
- **`order_full`:** registered; updates the cycle after the push or pop that changes the count.
- **`drop_count`:** updates the cycle after a rejected `order_go`.

## Configuration

- `ORDER_TX_CSUM_EN` defined: 5-byte frames including the CSUM state and checksum byte.
- `ORDER_TX_CSUM_EN` undefined:
  - The CSUM state is not compiled in; frames are 4 bytes.
  - Acceptance in AMT_LO performs the CSUM-exit behaviour: pop and go to SOF, or go to IDLE.

## Test plan

1. **Single frame:** reset, then `order_go` with client 5'd3, amount 16'h1234, `link_ready`=1 → bytes A5, 03, 12, 34, 25 on consecutive cycles. First valid byte 2 cycles after the strobe; `link_sof` high on A5 only.
2. **Backpressure:** as test 1, but `link_ready`=0 for 3 cycles while AMT_HI is presented → `link_data`=8'h12 and `link_valid`=1 held for those 3 cycles. No byte is lost or duplicated.
3. **Overflow:** `link_ready`=0, 6 back-to-back `order_go` strobes with amounts 1–6 at depth 4.
   - Order 1 sits in the frame register; orders 2–5 fill the FIFO; order 6 is dropped.
   - Required: `order_full`=1 and `drop_count`=1.
   - After `link_ready`=1: exactly 5 frames with amounts 1–5, in order.
4. **Back-to-back frames:** two queued orders, `link_ready`=1 → the SOF of frame 2 appears in the cycle immediately after the CSUM of frame 1 is accepted; `busy` drops after the last byte.
5. **Reset mid-frame:** assert `HRESETn` while AMT_LO is presented with 2 orders queued → outputs go to 0 without waiting for a clock edge. After release, `link_valid` stays 0 and `busy`=0.
6. **Checksum compiled out:** `ORDER_TX_CSUM_EN` undefined, stimulus as test 1 → 4 bytes A5, 03, 12, 34, then `link_valid`=0.
